jt1943_fmsched: RTL and testbench

JT1943_FMSCHED -- requirements
Module: jt1943_fmsched

---
 rtl/jt1943_fmsched.sv | 165 ++++++++++++++++
 tb/tb_jt1943_fmsched.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt1943_fmsched.sv
// FM chip write scheduler for two YM2203-class chips sharing one bus.
// CPU writes are queued in a small FIFO and replayed to the chips with a
// strobe that spans one cen1p5 tick. Each strobe is followed by an idle gap,
// which is short after an address write and long after a data write. CPU
// reads are held off with wait_n until the queue is drained and the
// sequencer is idle. After that they pass straight through to the selected
// chip.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cen1p5            FM chip clock enable
//   cpu_cs0/cpu_cs1   CPU chip selects (both high selects chip 1)
//   cpu_a0, cpu_wr_n, cpu_rd_n, cpu_din, cpu_dout, wait_n   CPU side
//   fm0_dout, fm1_dout                 chip read data
//   fm0_cs_n, fm1_cs_n, fm_wr_n, fm_a0, fm_din   shared chip bus
//   busy              queue non-empty or sequencer active
//   level             queue occupancy
module jt1943_fmsched #(
   parameter int unsigned FIFO_AW  = 2,
   parameter int unsigned ADDR_GAP = 4,
   parameter int unsigned DATA_GAP = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cen1p5,
   input  logic               cpu_cs0,
   input  logic               cpu_cs1,
   input  logic               cpu_a0,
   input  logic               cpu_wr_n,
   input  logic               cpu_rd_n,
   input  logic [7:0]         cpu_din,
   output logic [7:0]         cpu_dout,
   output logic               wait_n,
   input  logic [7:0]         fm0_dout,
   input  logic [7:0]         fm1_dout,
   output logic               fm0_cs_n,
   output logic               fm1_cs_n,
   output logic               fm_wr_n,
   output logic               fm_a0,
   output logic [7:0]         fm_din,
   output logic               busy,
   output logic [FIFO_AW:0]   level
);

   localparam int unsigned Depth  = 1 << FIFO_AW;
   localparam int unsigned MaxGap = (ADDR_GAP > DATA_GAP) ? ADDR_GAP : DATA_GAP;
   localparam int unsigned CntW   = $clog2(MaxGap + 2);

   localparam logic [FIFO_AW:0] LvlFull  = (FIFO_AW + 1)'(Depth);
   localparam logic [CntW-1:0]  AddrGapC = CntW'(ADDR_GAP);
   localparam logic [CntW-1:0]  DataGapC = CntW'(DATA_GAP);
   localparam logic [CntW-1:0]  CntOne   = CntW'(1);

   typedef enum logic [1:0] {StIdle, StStrobe, StGap} state_t;

   // Entry layout: {chip, a0, data}
   logic [9:0]         mem [Depth];
   logic [9:0]         head;
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   level_q;
   logic               acc_done_q;

   state_t             state_q;
   logic               seen_cen_q;
   logic [CntW-1:0]    cnt_q;
   logic               fm0_cs_n_q, fm1_cs_n_q, fm_wr_n_q, fm_a0_q;
   logic [7:0]         fm_din_q;

   logic acc, rq, full, push, pop, rd_ok;

   always_comb begin
      acc   = (cpu_cs0 | cpu_cs1) & ~cpu_wr_n;
      rq    = (cpu_cs0 | cpu_cs1) & ~cpu_rd_n;
      // Full is taken from the registered level, so a pop in the same
      // cycle cannot make room for a push.
      full  = (level_q == LvlFull);
      push  = acc & ~acc_done_q & ~full;
      pop   = (state_q == StIdle) && (level_q != '0);
      head  = mem[rd_ptr_q];
      busy  = (level_q != '0) || (state_q != StIdle);
      rd_ok = rq & ~busy;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {cpu_cs1, cpu_a0, cpu_din};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         acc_done_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      level_q <= level_q + 1'b1;
         else if (!push && pop) level_q <= level_q - 1'b1;
         // One entry per access: stays set until the write request drops.
         acc_done_q <= acc & (acc_done_q | push);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         seen_cen_q <= 1'b0;
         cnt_q      <= '0;
         fm0_cs_n_q <= 1'b1;
         fm1_cs_n_q <= 1'b1;
         fm_wr_n_q  <= 1'b1;
         fm_a0_q    <= 1'b0;
         fm_din_q   <= 8'h00;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  state_q    <= StStrobe;
                  seen_cen_q <= 1'b0;
                  fm_din_q   <= head[7:0];
                  fm_a0_q    <= head[8];
                  fm0_cs_n_q <= head[9];
                  fm1_cs_n_q <= ~head[9];
                  fm_wr_n_q  <= 1'b0;
               end
            end
            StStrobe: begin
               // Release one clk after the chip has seen a cen1p5 edge.
               if (seen_cen_q) begin
                  fm0_cs_n_q <= 1'b1;
                  fm1_cs_n_q <= 1'b1;
                  fm_wr_n_q  <= 1'b1;
                  cnt_q      <= fm_a0_q ? DataGapC : AddrGapC;
                  state_q    <= StGap;
               end else if (cen1p5) begin
                  seen_cen_q <= 1'b1;
               end
            end
            StGap: begin
               if (cnt_q == '0) begin
                  state_q <= StIdle;
               end else if (cen1p5) begin
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == CntOne) state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Reads pass through only when the sequencer is idle, so the registered
   // write strobes are inactive and the chip selects cannot collide.
   always_comb begin
      wait_n   = ~((acc & ~acc_done_q & full) | (rq & busy));
      fm0_cs_n = fm0_cs_n_q & ~(rd_ok & ~cpu_cs1);
      fm1_cs_n = fm1_cs_n_q & ~(rd_ok & cpu_cs1);
      fm_wr_n  = fm_wr_n_q;
      fm_a0    = rd_ok ? cpu_a0 : fm_a0_q;
      fm_din   = fm_din_q;
      cpu_dout = cpu_cs1 ? fm1_dout : fm0_dout;
      level    = level_q;
   end

endmodule

// File: tb/tb_jt1943_fmsched.sv
// Directed bench for jt1943_fmsched: cen1p5 pulses one clk in four, and a
// monitor logs every write strobe with the cen1p5 ticks seen during the
// strobe and during the following gap.
module tb_jt1943_fmsched;

   logic       clk = 1'b0;
   logic       rst, cen1p5;
   logic       cpu_cs0, cpu_cs1, cpu_a0, cpu_wr_n, cpu_rd_n;
   logic [7:0] cpu_din, cpu_dout, fm0_dout, fm1_dout, fm_din;
   logic       wait_n, fm0_cs_n, fm1_cs_n, fm_wr_n, fm_a0, busy;
   logic [2:0] level;

   int n_cmp  = 0;
   int n_fail = 0;

   jt1943_fmsched #(.FIFO_AW(2), .ADDR_GAP(4), .DATA_GAP(16)) dut (
      .clk(clk), .rst(rst), .cen1p5(cen1p5),
      .cpu_cs0(cpu_cs0), .cpu_cs1(cpu_cs1), .cpu_a0(cpu_a0),
      .cpu_wr_n(cpu_wr_n), .cpu_rd_n(cpu_rd_n), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .wait_n(wait_n),
      .fm0_dout(fm0_dout), .fm1_dout(fm1_dout),
      .fm0_cs_n(fm0_cs_n), .fm1_cs_n(fm1_cs_n), .fm_wr_n(fm_wr_n),
      .fm_a0(fm_a0), .fm_din(fm_din), .busy(busy), .level(level)
   );

   always #5 clk = ~clk;

   int cen_cnt = 0;
   always @(negedge clk) begin
      cen_cnt = (cen_cnt + 1) % 4;
      cen1p5  = (cen_cnt == 0);
   end

   typedef struct {
      logic       chip;
      logic       a0;
      logic [7:0] din;
      int         scen;
      int         gcen;
   } rec_t;

   rec_t log_q[$];
   rec_t cur;
   bit   in_strobe = 0;
   bit   in_gap    = 0;
   int   both_low_cnt = 0;
   int   wr_low_cnt   = 0;
   int   max_level    = 0;

   always @(negedge clk) begin
      #2;
      if (!fm0_cs_n && !fm1_cs_n) both_low_cnt++;
      if (!fm_wr_n) wr_low_cnt++;
      if (int'(level) > max_level) max_level = int'(level);
      if (!fm_wr_n) begin
         if (!in_strobe) begin
            if (in_gap) log_q.push_back(cur);
            in_gap    = 0;
            in_strobe = 1;
            cur.chip  = ~fm1_cs_n;
            cur.a0    = fm_a0;
            cur.din   = fm_din;
            cur.scen  = 0;
            cur.gcen  = 0;
         end
         if (cen1p5) cur.scen++;
      end else if (in_strobe) begin
         in_strobe = 0;
         in_gap    = 1;
         if (cen1p5) cur.gcen++;
      end else if (in_gap) begin
         if (!busy) begin
            log_q.push_back(cur);
            in_gap = 0;
         end else if (cen1p5) begin
            cur.gcen++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   task automatic cpu_write(input logic c0, input logic c1, input logic a0,
                            input logic [7:0] d, output bit waited);
      int n;
      waited = 0;
      n = 0;
      @(negedge clk);
      cpu_cs0 = c0; cpu_cs1 = c1; cpu_a0 = a0; cpu_din = d; cpu_wr_n = 1'b0;
      #1;
      while (wait_n !== 1'b1 && n < 500) begin
         waited = 1;
         @(negedge clk); #1;
         n++;
      end
      n_cmp++;
      if (n >= 500) begin
         n_fail++;
         $display("FAIL write_accept: wait_n=%b after %0d clks, required 1", wait_n, n);
      end
      @(posedge clk);
      @(negedge clk);
      cpu_cs0 = 1'b0; cpu_cs1 = 1'b0; cpu_wr_n = 1'b1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk); #1;
      while (busy !== 1'b0 && n < 2000) begin
         @(negedge clk); #1;
         n++;
      end
      n_cmp++;
      if (n >= 2000) begin
         n_fail++;
         $display("FAIL wait_idle: busy=%b after %0d clks, required 0", busy, n);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      n_cmp += 8;
      if (fm0_cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_fm0_cs_n: got %b, required 1", fm0_cs_n); end
      if (fm1_cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_fm1_cs_n: got %b, required 1", fm1_cs_n); end
      if (fm_wr_n !== 1'b1)  begin n_fail++; $display("FAIL rst_fm_wr_n: got %b, required 1", fm_wr_n); end
      if (fm_a0 !== 1'b0)    begin n_fail++; $display("FAIL rst_fm_a0: got %b, required 0", fm_a0); end
      if (fm_din !== 8'h00)  begin n_fail++; $display("FAIL rst_fm_din: got %h, required 00", fm_din); end
      if (wait_n !== 1'b1)   begin n_fail++; $display("FAIL rst_wait_n: got %b, required 1", wait_n); end
      if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
      if (level !== 3'd0)    begin n_fail++; $display("FAIL rst_level: got %0d, required 0", level); end
   endtask

   task automatic test_single_write();
      bit   w;
      rec_t r;
      log_q.delete();
      cpu_write(1'b1, 1'b0, 1'b0, 8'h27, w);
      n_cmp++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b, required 1", busy); end
      wait_idle();
      n_cmp++;
      if (log_q.size() != 1) begin
         n_fail++; $display("FAIL single_count: got %0d strobes, required 1", log_q.size());
      end
      if (log_q.size() > 0) begin
         r = log_q[0];
         n_cmp++;
         if (r.chip !== 1'b0 || r.a0 !== 1'b0 || r.din !== 8'h27 || r.scen != 1 || r.gcen != 4) begin
            n_fail++;
            $display("FAIL single_strobe: got chip=%b a0=%b din=%h scen=%0d gcen=%0d, required 0 0 27 1 4",
                     r.chip, r.a0, r.din, r.scen, r.gcen);
         end
      end
      n_cmp += 2;
      if (fm_din !== 8'h27) begin n_fail++; $display("FAIL single_din_hold: got %h, required 27", fm_din); end
      if (level !== 3'd0)   begin n_fail++; $display("FAIL single_level: got %0d, required 0", level); end

      // Both selects high: the write belongs to chip 1; a data write gets the long gap.
      log_q.delete();
      cpu_write(1'b1, 1'b1, 1'b1, 8'hA5, w);
      wait_idle();
      n_cmp++;
      if (log_q.size() != 1) begin
         n_fail++; $display("FAIL dual_cs_count: got %0d strobes, required 1", log_q.size());
      end
      if (log_q.size() > 0) begin
         r = log_q[0];
         n_cmp++;
         if (r.chip !== 1'b1 || r.a0 !== 1'b1 || r.din !== 8'hA5 || r.scen != 1 || r.gcen != 16) begin
            n_fail++;
            $display("FAIL dual_cs_strobe: got chip=%b a0=%b din=%h scen=%0d gcen=%0d, required 1 1 a5 1 16",
                     r.chip, r.a0, r.din, r.scen, r.gcen);
         end
      end
   endtask

   task automatic test_burst();
      logic [7:0] dat [6];
      logic       a0s [6];
      logic       chs [6];
      bit         w;
      int         n;
      logic [2:0] lvl_prev;
      rec_t       r;
      dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      a0s = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      chs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      log_q.delete();
      // The first entry is popped at once, so writes 2..5 fill the queue
      // and the sixth is the one that has to wait.
      for (int i = 0; i < 5; i++) begin
         cpu_write(~chs[i], chs[i], a0s[i], dat[i], w);
         n_cmp++;
         if (w) begin n_fail++; $display("FAIL burst_early_wait: write %0d waited, required no wait", i); end
      end
      @(negedge clk);
      cpu_cs0 = ~chs[5]; cpu_cs1 = chs[5]; cpu_a0 = a0s[5]; cpu_din = dat[5]; cpu_wr_n = 1'b0;
      #1;
      n_cmp++;
      if (wait_n !== 1'b0 || level !== 3'd4) begin
         n_fail++; $display("FAIL burst_full: got wait_n=%b level=%0d, required 0 4", wait_n, level);
      end
      n = 0;
      lvl_prev = level;
      while (wait_n !== 1'b1 && n < 500) begin
         lvl_prev = level;
         @(negedge clk); #1;
         n++;
      end
      n_cmp += 3;
      if (n >= 500) begin n_fail++; $display("FAIL burst_wait_timeout: wait_n=%b, required 1", wait_n); end
      if (lvl_prev !== 3'd4) begin
         n_fail++; $display("FAIL burst_refused_level: got %0d while refused, required 4", lvl_prev);
      end
      // Pop happened on the refused clk; the push lands on the next one.
      if (level !== 3'd3) begin
         n_fail++; $display("FAIL burst_pop_level: got %0d, required 3", level);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (level !== 3'd4 || wait_n !== 1'b1) begin
         n_fail++; $display("FAIL burst_accept_next: got level=%0d wait_n=%b, required 4 1", level, wait_n);
      end
      @(negedge clk);
      cpu_cs0 = 1'b0; cpu_cs1 = 1'b0; cpu_wr_n = 1'b1;
      wait_idle();
      n_cmp++;
      if (log_q.size() != 6) begin
         n_fail++; $display("FAIL burst_count: got %0d strobes, required 6", log_q.size());
      end
      for (int i = 0; i < 6; i++) begin
         if (i < log_q.size()) begin
            r = log_q[i];
            n_cmp++;
            if (r.chip !== chs[i] || r.a0 !== a0s[i] || r.din !== dat[i] || r.scen != 1 ||
                r.gcen != (a0s[i] ? 16 : 4)) begin
               n_fail++;
               $display("FAIL burst_entry%0d: got chip=%b a0=%b din=%h scen=%0d gcen=%0d, required %b %b %h 1 %0d",
                        i, r.chip, r.a0, r.din, r.scen, r.gcen, chs[i], a0s[i], dat[i],
                        a0s[i] ? 16 : 4);
            end
         end
      end
   endtask

   task automatic test_write_hold();
      log_q.delete();
      max_level = 0;
      @(negedge clk);
      cpu_cs0 = 1'b1; cpu_a0 = 1'b0; cpu_din = 8'h3C; cpu_wr_n = 1'b0;
      repeat (20) @(negedge clk);
      cpu_cs0 = 1'b0; cpu_wr_n = 1'b1;
      wait_idle();
      n_cmp += 2;
      if (log_q.size() != 1) begin
         n_fail++; $display("FAIL hold_count: got %0d strobes, required 1", log_q.size());
      end else if (log_q[0].din !== 8'h3C) begin
         n_fail++; $display("FAIL hold_count: got din %h, required 3c", log_q[0].din);
      end
      if (max_level != 1) begin
         n_fail++; $display("FAIL hold_level: got max level %0d, required 1", max_level);
      end
   endtask

   task automatic test_read_wait();
      bit w;
      bit bad_wait;
      int n;
      log_q.delete();
      cpu_write(1'b1, 1'b0, 1'b1, 8'h01, w);
      cpu_write(1'b1, 1'b0, 1'b0, 8'h02, w);
      @(negedge clk);
      fm1_dout = 8'h80; fm0_dout = 8'h5E;
      cpu_cs1 = 1'b1; cpu_a0 = 1'b1; cpu_rd_n = 1'b0;
      #1;
      n_cmp += 2;
      if (wait_n !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL read_wait_start: got wait_n=%b busy=%b, required 0 1", wait_n, busy);
      end
      if (cpu_dout !== 8'h80) begin
         n_fail++; $display("FAIL read_dout_cs1: got %h, required 80", cpu_dout);
      end
      n = 0;
      bad_wait = 0;
      while (wait_n !== 1'b1 && n < 2000) begin
         if (busy !== 1'b1 || fm1_cs_n !== 1'b1) bad_wait = 1;
         @(negedge clk); #1;
         n++;
      end
      n_cmp += 3;
      if (n >= 2000) begin n_fail++; $display("FAIL read_wait_timeout: wait_n=%b, required 1", wait_n); end
      if (bad_wait) begin
         n_fail++; $display("FAIL read_wait_state: wait held with busy=0 or fm1 selected, required busy=1 fm1_cs_n=1");
      end
      if (busy !== 1'b0 || fm1_cs_n !== 1'b0 || fm0_cs_n !== 1'b1 || fm_wr_n !== 1'b1 ||
          fm_a0 !== 1'b1 || cpu_dout !== 8'h80) begin
         n_fail++;
         $display("FAIL read_pass: got busy=%b cs1_n=%b cs0_n=%b wr_n=%b a0=%b dout=%h, required 0 0 1 1 1 80",
                  busy, fm1_cs_n, fm0_cs_n, fm_wr_n, fm_a0, cpu_dout);
      end
      @(negedge clk);
      cpu_cs1 = 1'b0; cpu_cs0 = 1'b1; cpu_a0 = 1'b0;
      #1;
      n_cmp++;
      if (wait_n !== 1'b1 || fm0_cs_n !== 1'b0 || fm1_cs_n !== 1'b1 || fm_a0 !== 1'b0 ||
          cpu_dout !== 8'h5E) begin
         n_fail++;
         $display("FAIL read_cs0: got wait_n=%b cs0_n=%b cs1_n=%b a0=%b dout=%h, required 1 0 1 0 5e",
                  wait_n, fm0_cs_n, fm1_cs_n, fm_a0, cpu_dout);
      end
      @(negedge clk);
      cpu_cs0 = 1'b0; cpu_rd_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_cmp += 2;
      if (log_q.size() != 2) begin
         n_fail++; $display("FAIL read_writes_done: got %0d strobes, required 2", log_q.size());
      end
      if (level !== 3'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL read_no_entry: got level=%0d busy=%b, required 0 0", level, busy);
      end
   endtask

   task automatic test_reset_mid_strobe();
      bit w;
      int n;
      for (int i = 0; i < 5; i++) cpu_write(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i), w);
      n = 0;
      #1;
      while (!(fm_wr_n === 1'b0 && level === 3'd3) && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      n_cmp++;
      if (n >= 500) begin
         n_fail++; $display("FAIL rst_mid_setup: got wr_n=%b level=%0d, required 0 3", fm_wr_n, level);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (fm0_cs_n !== 1'b1 || fm1_cs_n !== 1'b1 || fm_wr_n !== 1'b1 || fm_a0 !== 1'b0 ||
          fm_din !== 8'h00 || wait_n !== 1'b1 || busy !== 1'b0 || level !== 3'd0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got cs0_n=%b cs1_n=%b wr_n=%b a0=%b din=%h wait_n=%b busy=%b level=%0d, required 1 1 1 0 00 1 0 0",
                  fm0_cs_n, fm1_cs_n, fm_wr_n, fm_a0, fm_din, wait_n, busy, level);
      end
      @(negedge clk);
      rst = 1'b0;
      wr_low_cnt = 0;
      repeat (100) @(negedge clk);
      #1;
      n_cmp++;
      if (wr_low_cnt != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_discard: got %0d strobe clks busy=%b, required 0 0", wr_low_cnt, busy);
      end
   endtask

   initial begin
      rst = 1'b1; cen1p5 = 1'b0;
      cpu_cs0 = 1'b0; cpu_cs1 = 1'b0; cpu_a0 = 1'b0; cpu_wr_n = 1'b1; cpu_rd_n = 1'b1;
      cpu_din = 8'h00; fm0_dout = 8'h00; fm1_dout = 8'h00;
      test_reset();
      test_single_write();
      test_burst();
      test_write_hold();
      test_read_wait();
      test_reset_mid_strobe();
      n_cmp++;
      if (both_low_cnt != 0) begin
         n_fail++; $display("FAIL cs_exclusive: got %0d clks with both selects low, required 0", both_low_cnt);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
